// File: rtl/cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_muldiv_if
//  Description : Request/response bundle between the execute stage and the
//                iterative RV32M multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    // Pipeline side: issues requests and aborts, consumes status and result.
    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, result
    );

    // Unit side.
    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_muldiv
//  Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//                multiply and restoring divide on operand magnitudes, one
//                bit per cycle over 32 cycles; divide-by-zero and signed
//                overflow resolve in a single cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_muldiv (
    input  wire logic   clk,
    input  wire logic   rst,
    cpu_muldiv_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] C_OP_MUL    = 3'b000;
    localparam logic [2:0] C_OP_MULH   = 3'b001;
    localparam logic [2:0] C_OP_MULHSU = 3'b010;
    localparam logic [2:0] C_OP_DIV    = 3'b100;
    localparam logic [2:0] C_OP_REM    = 3'b110;

    localparam logic [5:0] C_LAST_ITER = 6'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_op;
    logic        r_sign;     // negate final product / quotient / remainder
    logic [5:0]  r_cnt;
    logic [31:0] r_opnd;     // multiplicand magnitude, or divisor magnitude
    logic [63:0] r_acc;      // {hi product, multiplier} or {remainder, dividend/quotient}
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sign_in;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_fast;
    logic [31:0] w_fast_val;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_trial;
    logic [31:0] w_div_sub;
    logic        w_div_borrow;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

    // Operand decode at accept: signedness, sign flag, magnitudes and fast paths.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        w_sign_in  = 1'b0;
        w_fast     = 1'b0;
        w_fast_val = 32'h0000_0000;
        case (bus.op)
            C_OP_MULH: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
                w_sign_in  = bus.src_a[31] ^ bus.src_b[31];
            end
            C_OP_MULHSU: begin
                w_a_signed = 1'b1;
                w_sign_in  = bus.src_a[31];
            end
            C_OP_DIV: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
                w_sign_in  = bus.src_a[31] ^ bus.src_b[31];
            end
            C_OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
                w_sign_in  = bus.src_a[31];
            end
            default: ;
        endcase
        w_mag_a = (w_a_signed && bus.src_a[31]) ? (32'h0 - bus.src_a) : bus.src_a;
        w_mag_b = (w_b_signed && bus.src_b[31]) ? (32'h0 - bus.src_b) : bus.src_b;
        // op[1] separates the remainder forms from the quotient forms.
        if (bus.op[2] && (bus.src_b == 32'h0000_0000)) begin
            w_fast     = 1'b1;
            w_fast_val = bus.op[1] ? bus.src_a : 32'hFFFF_FFFF;
        end else if (((bus.op == C_OP_DIV) || (bus.op == C_OP_REM)) &&
                     (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF)) begin
            w_fast     = 1'b1;
            w_fast_val = bus.op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_mul_sum    = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'h0000_0000)};
        w_div_trial  = {r_acc[63:32], r_acc[31]};
        w_div_borrow = (w_div_trial < {1'b0, r_opnd});
        w_div_sub    = w_div_trial[31:0] - r_opnd;
        if (r_op[2]) begin
            w_acc_nxt = w_div_borrow ? {w_div_trial[31:0], r_acc[30:0], 1'b0}
                                     : {w_div_sub,         r_acc[30:0], 1'b1};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[31:1]};
        end
    end

    // Sign fix-up and result selection from the post-final-iteration accumulator.
    always_comb begin
        w_prod  = r_sign ? (64'h0 - w_acc_nxt) : w_acc_nxt;
        w_quo   = r_sign ? (32'h0 - w_acc_nxt[31:0])  : w_acc_nxt[31:0];
        w_rem   = r_sign ? (32'h0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];
        w_final = w_prod[63:32];
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else if (r_op == C_OP_MUL) begin
            w_final = w_prod[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_fast ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: latch operands at accept, iterate in ITER, load result entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 3'b000;
            r_sign   <= 1'b0;
            r_cnt    <= 6'd0;
            r_opnd   <= 32'h0000_0000;
            r_acc    <= 64'h0;
            r_result <= 32'h0000_0000;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_sign <= w_sign_in;
            r_cnt  <= 6'd0;
            r_opnd <= bus.op[2] ? w_mag_b : w_mag_a;
            r_acc  <= {32'h0000_0000, (bus.op[2] ? w_mag_a : w_mag_b)};
            if (w_fast) begin
                r_result <= w_fast_val;
            end
        end else if ((r_state == S_ITER) && !bus.flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == C_LAST_ITER) begin
                r_result <= w_final;
            end
        end
    end

    assign bus.busy   = (r_state == S_ITER);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_muldiv
//  Description : Self-checking bench for cpu_muldiv: directed RV32M corner
//                cases, flush/reset/ignored-start behaviour and randomized
//                operations against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_muldiv;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] last_res = 32'h0;

    cpu_muldiv_if bus ();

    cpu_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics written directly from the instruction definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one operation and check latency, busy duration, result and pulse width.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit noise);
        int          lat;
        int          busy_cnt;
        logic [31:0] res;
        bit          fast;
        fast     = is_fast(op, a, b);
        lat      = 0;
        busy_cnt = 0;
        res      = 'x;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk); #1;
        bus.start = noise;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
            if (noise) begin
                bus.op    = 3'($urandom);
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            @(posedge clk); #1;
        end
        chk({tag, ".latency"}, lat, fast ? 1 : 33);
        chk({tag, ".busy_cycles"}, busy_cnt, fast ? 0 : 32);
        chk({tag, ".result"}, res, exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, ".done_pulse"}, {31'h0, bus.done}, 32'h0);
        chk({tag, ".no_reaccept"}, {31'h0, bus.busy}, 32'h0);
        chk({tag, ".result_hold"}, bus.result, exp);
        last_res = exp;
    endtask

    // Count done pulses over a window; used after aborts.
    task automatic quiet_window(input string tag);
        int dn;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk({tag, ".no_done"}, dn, 0);
        chk({tag, ".result_kept"}, bus.result, last_res);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'd0;
        bus.src_a = 32'h0;
        bus.src_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", {31'h0, bus.busy}, 32'h0);
        chk("reset.done", {31'h0, bus.done}, 32'h0);
        chk("reset.result", bus.result, 32'h0);
        rst = 1'b0;

        run_op("mul",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh",       3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        run_op("rem",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
        run_op("divu",       3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0);
        run_op("remu",       3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 1'b0);
        run_op("div_by0",    3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_by0",   3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("start_in_iter", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);

        // Flush in the 10th ITER cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("flush.busy_before", {31'h0, bus.busy}, 32'h1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush.busy_after", {31'h0, bus.busy}, 32'h0);
        quiet_window("flush");

        // Flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.src_a = 32'd5; bus.src_b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start.busy", {31'h0, bus.busy}, 32'h0);
        chk("flush_start.done", {31'h0, bus.done}, 32'h0);
        quiet_window("flush_start");

        // Reset mid-ITER clears everything, including result.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid.busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_mid.done", {31'h0, bus.done}, 32'h0);
        chk("rst_mid.result", bus.result, 32'h0);
        last_res = 32'h0;
        quiet_window("rst_mid");

        // Randomized operations with biased operand classes.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_model(op, a, b), 1'(i % 5 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
